// File: rtl/issue_unit.sv
// In-order issue stage: per-register scoreboard for RAW/WAW plus a writeback-slot
// reservation vector so results from different functional units never collide.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 4
`endif
`ifndef INS_FUNC
`define INS_FUNC 4
`endif
`ifndef MODMUL
`define MODMUL 21
`endif
`ifndef OP_ADD
`define OP_ADD 0
`define OP_SUB 1
`define OP_NEG 2
`define OP_DBL 3
`define OP_TPL 4
`define OP_SQR 5
`define OP_MUL 6
`define OP_CVT 7
`define OP_ICV 8
`define OP_INV 9
`endif

module issue_unit #(
    parameter int WORDSZ   = `WORDSZ,
    parameter int RFSZLOG2 = `RFSZLOG2,
    parameter int INS_FUNC = `INS_FUNC,
    parameter int LAT_MUL  = `MODMUL,
    parameter int LAT_LIN  = 4,
    parameter int LAT_TPL  = 4,
    parameter int LAT_INV  = 64,
    parameter int MAXLAT   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ins_valid,
    output logic                ins_ready,
    input  logic                ins_halt,
    input  logic [INS_FUNC-1:0] ins_func,
    input  logic [RFSZLOG2-1:0] ins_rd,
    input  logic [RFSZLOG2-1:0] ins_rs0,
    input  logic [RFSZLOG2-1:0] ins_rs1,
    output logic [RFSZLOG2-1:0] rf_raddr0,
    output logic [RFSZLOG2-1:0] rf_raddr1,
    input  logic [WORDSZ-1:0]   rf_rdata0,
    input  logic [WORDSZ-1:0]   rf_rdata1,
    output logic [INS_FUNC-1:0] func_op,
    output logic                ex_valid,
    output logic [WORDSZ-1:0]   op_0,
    output logic [WORDSZ-1:0]   op_1,
    output logic [RFSZLOG2-1:0] rn_df,
    output logic                run_if,
    output logic                halt_ex,
    input  logic [RFSZLOG2-1:0] wb_addr
);
    localparam int NREG = 1 << RFSZLOG2;
    localparam int RW   = MAXLAT + 2;
    localparam int LW   = $clog2(RW + 1);
    localparam int CW   = $clog2(LAT_INV + 2);

    localparam logic [INS_FUNC-1:0] OPC_ADD = INS_FUNC'(`OP_ADD);
    localparam logic [INS_FUNC-1:0] OPC_SUB = INS_FUNC'(`OP_SUB);
    localparam logic [INS_FUNC-1:0] OPC_NEG = INS_FUNC'(`OP_NEG);
    localparam logic [INS_FUNC-1:0] OPC_DBL = INS_FUNC'(`OP_DBL);
    localparam logic [INS_FUNC-1:0] OPC_TPL = INS_FUNC'(`OP_TPL);
    localparam logic [INS_FUNC-1:0] OPC_SQR = INS_FUNC'(`OP_SQR);
    localparam logic [INS_FUNC-1:0] OPC_MUL = INS_FUNC'(`OP_MUL);
    localparam logic [INS_FUNC-1:0] OPC_CVT = INS_FUNC'(`OP_CVT);
    localparam logic [INS_FUNC-1:0] OPC_ICV = INS_FUNC'(`OP_ICV);
    localparam logic [INS_FUNC-1:0] OPC_INV = INS_FUNC'(`OP_INV);

    logic [INS_FUNC-1:0] func_q, func_d;
    logic [WORDSZ-1:0]   op0_q, op0_d, op1_q, op1_d;
    logic [RFSZLOG2-1:0] rn_q, rn_d;
    logic                ex_valid_q, ex_valid_d;
    logic                run_if_q, run_if_d;
    logic                halt_ex_q, halt_ex_d;
    logic                halted_q, halted_d;
    logic [NREG-1:0]     pending_q, pending_d;
    logic [RW-1:0]       resv_q, resv_d;
    logic [CW-1:0]       inv_cnt_q, inv_cnt_d;

    logic          legal, is_inv, inv_busy, hazard_ok, norm_acc, halt_acc;
    logic [LW-1:0] lat, lat_p1;

    always_comb begin
        legal  = 1'b1;
        is_inv = 1'b0;
        lat    = '0;
        case (ins_func)
            OPC_SQR, OPC_MUL, OPC_CVT, OPC_ICV: lat = LW'(LAT_MUL);
            OPC_ADD, OPC_SUB, OPC_NEG, OPC_DBL: lat = LW'(LAT_LIN);
            OPC_TPL:                            lat = LW'(LAT_TPL);
            OPC_INV: begin
                lat    = LW'(LAT_INV);
                is_inv = 1'b1;
            end
            default:                            legal = 1'b0;
        endcase
        lat_p1 = lat + LW'(1);
    end

    // resv_q[i] marks a writeback i cycles from now; a new issue lands at lat+1
    assign inv_busy  = (inv_cnt_q != '0);
    assign hazard_ok = !pending_q[ins_rs0] && !pending_q[ins_rs1] && !pending_q[ins_rd]
                       && !(legal && resv_q[lat_p1]) && !(is_inv && inv_busy);
    assign norm_acc  = ins_valid && !ins_halt && !halted_q && hazard_ok;
    assign halt_acc  = ins_valid && ins_halt && !halted_q;
    assign ins_ready = norm_acc || halt_acc;

    always_comb begin
        func_d     = func_q;
        op0_d      = op0_q;
        op1_d      = op1_q;
        rn_d       = rn_q;
        ex_valid_d = norm_acc;
        halt_ex_d  = halt_acc;
        halted_d   = halted_q || halt_acc;
        run_if_d   = run_if_q;
        pending_d  = pending_q;
        resv_d     = resv_q >> 1;
        inv_cnt_d  = inv_busy ? inv_cnt_q - CW'(1) : '0;

        if (halt_acc)
            run_if_d = 1'b0;
        else if (norm_acc)
            run_if_d = 1'b1;

        if (wb_addr != '0)
            pending_d[wb_addr] = 1'b0;

        if (norm_acc) begin
            func_d = ins_func;
            op0_d  = rf_rdata0;
            op1_d  = rf_rdata1;
            rn_d   = ins_rd;
            if (legal) begin
                resv_d[lat] = 1'b1;
                if (ins_rd != '0)
                    pending_d[ins_rd] = 1'b1;
            end
            // Loaded one below LAT_INV+1: the load cycle counts as the first decrement
            if (is_inv)
                inv_cnt_d = CW'(LAT_INV);
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            func_q     <= '0;
            op0_q      <= '0;
            op1_q      <= '0;
            rn_q       <= '0;
            ex_valid_q <= 1'b0;
            run_if_q   <= 1'b0;
            halt_ex_q  <= 1'b0;
            halted_q   <= 1'b0;
            pending_q  <= '0;
            resv_q     <= '0;
            inv_cnt_q  <= '0;
        end else begin
            func_q     <= func_d;
            op0_q      <= op0_d;
            op1_q      <= op1_d;
            rn_q       <= rn_d;
            ex_valid_q <= ex_valid_d;
            run_if_q   <= run_if_d;
            halt_ex_q  <= halt_ex_d;
            halted_q   <= halted_d;
            pending_q  <= pending_d;
            resv_q     <= resv_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

    assign rf_raddr0 = ins_rs0;
    assign rf_raddr1 = ins_rs1;
    assign func_op   = func_q;
    assign op_0      = op0_q;
    assign op_1      = op1_q;
    assign rn_df     = rn_q;
    assign ex_valid  = ex_valid_q;
    assign run_if    = run_if_q;
    assign halt_ex   = halt_ex_q;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: a cycle-time reference model predicts acceptance
// and issued fields; a separate monitor checks every ex_valid against the queue.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 4
`endif
`ifndef INS_FUNC
`define INS_FUNC 4
`endif
`ifndef MODMUL
`define MODMUL 21
`endif
`ifndef OP_ADD
`define OP_ADD 0
`define OP_SUB 1
`define OP_NEG 2
`define OP_DBL 3
`define OP_TPL 4
`define OP_SQR 5
`define OP_MUL 6
`define OP_CVT 7
`define OP_ICV 8
`define OP_INV 9
`endif

module tb_issue_unit;
    localparam int W     = `WORDSZ;
    localparam int RB    = `RFSZLOG2;
    localparam int FB    = `INS_FUNC;
    localparam int NREG  = 1 << RB;
    localparam int L_MUL = `MODMUL;
    localparam int L_LIN = 4;
    localparam int L_TPL = 4;
    localparam int L_INV = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ins_valid = 1'b0, ins_halt = 1'b0, ins_ready;
    logic [FB-1:0] ins_func = '0;
    logic [RB-1:0] ins_rd = '0, ins_rs0 = '0, ins_rs1 = '0;
    logic [RB-1:0] rf_raddr0, rf_raddr1, rn_df;
    logic [W-1:0]  rf_rdata0, rf_rdata1, op_0, op_1;
    logic [FB-1:0] func_op;
    logic          ex_valid, run_if, halt_ex;
    logic [RB-1:0] wb_addr = '0;

    always #5 clk = ~clk;

    issue_unit dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_halt(ins_halt), .ins_func(ins_func), .ins_rd(ins_rd),
        .ins_rs0(ins_rs0), .ins_rs1(ins_rs1), .rf_raddr0(rf_raddr0),
        .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .func_op(func_op), .ex_valid(ex_valid), .op_0(op_0), .op_1(op_1),
        .rn_df(rn_df), .run_if(run_if), .halt_ex(halt_ex), .wb_addr(wb_addr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] rf_mem [NREG];
    assign rf_rdata0 = rf_mem[rf_raddr0];
    assign rf_rdata1 = rf_mem[rf_raddr1];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    endtask

    typedef struct {
        int            at;
        logic [FB-1:0] func;
        logic [W-1:0]  op0;
        logic [W-1:0]  op1;
        logic [RB-1:0] rd;
    } exp_t;
    exp_t expq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            if (expq.size() == 0) chk("issue_without_expect", 64'(ex_valid), 64'(0));
            else begin
                mon_e = expq.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(mon_e.at));
                chk("func_op", 64'(func_op), 64'(mon_e.func));
                chk("op_0", 64'(op_0), 64'(mon_e.op0));
                chk("op_1", 64'(op_1), 64'(mon_e.op1));
                chk("rn_df", 64'(rn_df), 64'(mon_e.rd));
            end
        end
    end

    // Reference model in absolute cycle numbers
    int ready_at[NREG];
    bit slot_busy[int];
    int env_wb[int];
    int inv_free = 0;
    bit m_halted = 0, m_run = 0;
    int halt_at = -10;

    function automatic int lat_of(input int f);
        case (f)
            `OP_SQR, `OP_MUL, `OP_CVT, `OP_ICV: return L_MUL;
            `OP_ADD, `OP_SUB, `OP_NEG, `OP_DBL: return L_LIN;
            `OP_TPL:                            return L_TPL;
            `OP_INV:                            return L_INV;
            default:                            return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) ready_at[i] = 0;
        slot_busy.delete();
        inv_free = 0;
        m_halted = 0;
        m_run    = 0;
        halt_at  = -10;
    endtask

    task automatic step(input bit r, input bit v, input bit h, input int f,
                        input int rd, input int rs0, input int rs1, output bit acc);
        int c, l;
        bit e;
        exp_t x;
        c = cyc;
        rst = r; ins_valid = v; ins_halt = h;
        ins_func = FB'(f); ins_rd = RB'(rd); ins_rs0 = RB'(rs0); ins_rs1 = RB'(rs1);
        wb_addr = env_wb.exists(c) ? RB'(env_wb[c]) : '0;
        @(negedge clk);
        l = lat_of(f);
        e = 0;
        if (v && !r && !m_halted) begin
            if (h) e = 1;
            else e = (c >= ready_at[rs0]) && (c >= ready_at[rs1]) && (c >= ready_at[rd])
                     && !(l >= 0 && slot_busy.exists(c + 1 + l))
                     && !(f == `OP_INV && c < inv_free);
        end
        if (!r) chk("ins_ready", 64'(ins_ready), 64'(e));
        chk("run_if", 64'(run_if), 64'(m_run));
        chk("halt_ex", 64'(halt_ex), 64'(halt_at == c - 1));
        if (r) model_reset();
        else if (e && h) begin
            m_halted = 1; m_run = 0; halt_at = c;
        end else if (e) begin
            x.at = c + 1; x.func = FB'(f); x.op0 = rf_mem[rs0]; x.op1 = rf_mem[rs1]; x.rd = RB'(rd);
            expq.push_back(x);
            m_run = 1;
            if (l >= 0) begin
                slot_busy[c + 1 + l] = 1;
                env_wb[c + 1 + l] = rd;
                if (rd != 0) ready_at[rd] = c + 2 + l;
            end
            if (f == `OP_INV) inv_free = c + 1 + L_INV;
        end
        acc = e;
        @(posedge clk);
        #1;
        if (wb_addr != '0) rf_mem[wb_addr] = $urandom;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic issue(input bit h, input int f, input int rd, input int rs0,
                         input int rs1, output int at);
        bit a;
        int c;
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            c = cyc;
            step(0, 1, h, f, rd, rs0, rs1, a);
            if (a) at = c;
        end
        if (at < 0) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int c0, at, f, rd, rs0, rs1;
        bit a, pend;
        for (int i = 0; i < NREG; i++) rf_mem[i] = $urandom;
        for (int i = 0; i < NREG; i++) ready_at[i] = 0;

        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ex_valid", 64'(ex_valid), 64'(0));
        chk("rst_func_op", 64'(func_op), 64'(0));
        chk("rst_op_0", 64'(op_0), 64'(0));
        chk("rst_op_1", 64'(op_1), 64'(0));
        chk("rst_rn_df", 64'(rn_df), 64'(0));
        chk("rst_run_if", 64'(run_if), 64'(0));
        chk("rst_halt_ex", 64'(halt_ex), 64'(0));
        @(posedge clk); #1;

        // Back-to-back independent ADDs
        c0 = cyc;
        for (int i = 1; i <= 4; i++) begin
            issue(0, `OP_ADD, i, 10, 11, at);
            chk("b2b_accept", 64'(at), 64'(c0 + i - 1));
        end
        idle(90);

        // RAW on a MUL result: no bypass
        c0 = cyc;
        issue(0, `OP_MUL, 5, 1, 2, at);
        issue(0, `OP_ADD, 6, 5, 1, at);
        chk("raw_mul_accept", 64'(at), 64'(c0 + 23));
        idle(90);

        // Writeback slot collision costs exactly one cycle
        c0 = cyc;
        issue(0, `OP_MUL, 7, 1, 2, at);
        idle(16);
        issue(0, `OP_ADD, 8, 1, 2, at);
        chk("slot_stall_accept", 64'(at), 64'(c0 + 18));
        idle(90);

        // INV serialisation with an independent ADD slipping in between
        c0 = cyc;
        issue(0, `OP_INV, 2, 1, 1, at);
        issue(0, `OP_ADD, 4, 1, 1, at);
        chk("inv_gap_add", 64'(at), 64'(c0 + 1));
        issue(0, `OP_INV, 3, 1, 1, at);
        chk("inv_serial", 64'(at), 64'(c0 + 65));
        idle(90);

        // Illegal opcode issues but leaves its destination free
        c0 = cyc;
        issue(0, 15, 9, 1, 2, at);
        issue(0, `OP_ADD, 10, 9, 9, at);
        chk("illegal_no_pending", 64'(at), 64'(c0 + 1));
        idle(90);

        // Randomised traffic; a stalled instruction is held until taken
        pend = 0;
        f = 0; rd = 0; rs0 = 0; rs1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend) begin
                f = $urandom_range(0, 9);
                if (f == `OP_INV && $urandom_range(0, 3) != 0) f = `OP_SUB;
                rd  = $urandom_range(0, 7);
                rs0 = $urandom_range(0, 7);
                rs1 = $urandom_range(0, 7);
                pend = 1;
            end
            if ($urandom_range(0, 4) == 0) step(0, 0, 0, f, rd, rs0, rs1, a);
            else begin
                step(0, 1, 0, f, rd, rs0, rs1, a);
                if (a) pend = 0;
            end
        end
        idle(90);

        // Mid-flight reset drops the scoreboard
        c0 = cyc;
        issue(0, `OP_MUL, 5, 1, 2, at);
        idle(9);
        step(1, 0, 0, 0, 0, 0, 0, a);
        chk("mid_rst_ex_valid", 64'(ex_valid), 64'(0));
        chk("mid_rst_func_op", 64'(func_op), 64'(0));
        chk("mid_rst_op_0", 64'(op_0), 64'(0));
        chk("mid_rst_op_1", 64'(op_1), 64'(0));
        chk("mid_rst_rn_df", 64'(rn_df), 64'(0));
        chk("mid_rst_run_if", 64'(run_if), 64'(0));
        issue(0, `OP_ADD, 6, 5, 1, at);
        chk("post_rst_accept", 64'(at), 64'(c0 + 11));
        idle(30);

        // HALT with a MUL in flight
        c0 = cyc;
        issue(0, `OP_MUL, 9, 1, 2, at);
        issue(1, 0, 0, 0, 0, at);
        chk("halt_accept", 64'(at), 64'(c0 + 1));
        for (int i = 0; i < 5; i++) step(0, 1, 0, `OP_ADD, 3, 1, 2, a);
        idle(25);

        chk("queue_drained", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
